// File: rtl/riscv_hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// riscv_hazard_scoreboard_if
//   Bundles the pipeline-side request signals and the hazard-unit responses
//   of riscv_hazard_scoreboard.
//   master : pipeline control (drives the i_* stage information, reads o_*)
//   slave  : hazard unit (reads i_*, drives forwarding selects, stall/flush,
//            scoreboard status and performance counters)
// ---------------------------------------------------------------------------
interface riscv_hazard_scoreboard_if #(
    parameter int REG_ADDR_BW = 5,
    parameter int CNT_BW      = 16
);
    // D stage
    logic [REG_ADDR_BW-1:0] i_rs1_addr_d;
    logic [REG_ADDR_BW-1:0] i_rs2_addr_d;
    logic [REG_ADDR_BW-1:0] i_rd_addr_d;
    logic                   i_md_op_d;
    // E stage
    logic [REG_ADDR_BW-1:0] i_rs1_addr_e;
    logic [REG_ADDR_BW-1:0] i_rs2_addr_e;
    logic [REG_ADDR_BW-1:0] i_rd_addr_e;
    logic                   i_is_load_e;
    logic                   i_md_start_e;
    // M stage
    logic [REG_ADDR_BW-1:0] i_rd_addr_m;
    logic                   i_reg_wr_en_m;
    logic                   i_is_load_m;
    // W stage
    logic [REG_ADDR_BW-1:0] i_rd_addr_w;
    logic                   i_reg_wr_en_w;
    // Control
    logic [1:0]             i_src_pc;
    logic                   i_cnt_clr;
    // Hazard unit responses
    logic [1:0]             o_forward_ae;
    logic [1:0]             o_forward_be;
    logic                   o_stall_f;
    logic                   o_stall_d;
    logic                   o_flush_d;
    logic                   o_flush_e;
    logic                   o_md_busy;
    logic [REG_ADDR_BW-1:0] o_md_rd;
    logic                   o_md_done;
    logic [CNT_BW-1:0]      o_stall_cnt;
    logic [CNT_BW-1:0]      o_flush_cnt;

    modport master (
        output i_rs1_addr_d, i_rs2_addr_d, i_rd_addr_d, i_md_op_d,
               i_rs1_addr_e, i_rs2_addr_e, i_rd_addr_e, i_is_load_e, i_md_start_e,
               i_rd_addr_m, i_reg_wr_en_m, i_is_load_m,
               i_rd_addr_w, i_reg_wr_en_w, i_src_pc, i_cnt_clr,
        input  o_forward_ae, o_forward_be, o_stall_f, o_stall_d, o_flush_d, o_flush_e,
               o_md_busy, o_md_rd, o_md_done, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_rs1_addr_d, i_rs2_addr_d, i_rd_addr_d, i_md_op_d,
               i_rs1_addr_e, i_rs2_addr_e, i_rd_addr_e, i_is_load_e, i_md_start_e,
               i_rd_addr_m, i_reg_wr_en_m, i_is_load_m,
               i_rd_addr_w, i_reg_wr_en_w, i_src_pc, i_cnt_clr,
        output o_forward_ae, o_forward_be, o_stall_f, o_stall_d, o_flush_d, o_flush_e,
               o_md_busy, o_md_rd, o_md_done, o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/riscv_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// riscv_hazard_scoreboard
//   Hazard unit for a 5-stage RV32I pipeline with a multi-cycle mul/div unit
//   in E. Produces E-stage forwarding selects, F/D/E stall and flush
//   controls, a single-entry scoreboard for the outstanding multi-cycle op,
//   and saturating stall/flush event counters.
//
//   Parameters : REG_ADDR_BW register address width
//                MD_LAT      multi-cycle latency, 2..15
//                LOAD_LAT    1 = load data in W, 2 = one cycle after M
//                CNT_BW      performance counter width
//   Ports      : i_clk   rising-edge clock
//                i_rstn  asynchronous active-low reset
//                hz      slave side of riscv_hazard_scoreboard_if
// ---------------------------------------------------------------------------
module riscv_hazard_scoreboard #(
    parameter int REG_ADDR_BW = 5,
    parameter int MD_LAT      = 4,
    parameter int LOAD_LAT    = 1,
    parameter int CNT_BW      = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    riscv_hazard_scoreboard_if.slave  hz
);
    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    localparam logic [3:0] MD_LAT_L = 4'(MD_LAT);
    localparam bit         LW_M_EN  = (LOAD_LAT == 2);

    typedef logic [REG_ADDR_BW-1:0] reg_addr_t;

    state_e            state_q, state_d;
    reg_addr_t         rd_q, rd_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CNT_BW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_BW-1:0] flush_cnt_q, flush_cnt_d;

    logic busy, md_done;
    logic lw_hz, md_hz, redirect, stall;

    // A source of x0 never forwards; M result is younger than W, so it wins.
    function automatic logic [1:0] fwd_sel(input reg_addr_t src,
                                           input reg_addr_t rd_m, input logic wr_m,
                                           input reg_addr_t rd_w, input logic wr_w);
        if (src == '0)                return 2'b00;
        else if (wr_m && src == rd_m) return 2'b10;
        else if (wr_w && src == rd_w) return 2'b01;
        else                          return 2'b00;
    endfunction

    // Does a D-stage source read the nonzero register rd?
    function automatic logic d_reads(input reg_addr_t rd, input reg_addr_t rs1,
                                     input reg_addr_t rs2);
        return (rd != '0) && ((rs1 == rd) || (rs2 == rd));
    endfunction

    // ---------------- scoreboard FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- scoreboard FSM: next state ----------------
    always_comb begin
        // NOTE: defaults first so every path assigns each signal (no latches).
        state_d = state_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hz.i_md_start_e) begin
                    state_d = ST_BUSY;
                    rd_d    = hz.i_rd_addr_e;
                    cnt_d   = MD_LAT_L;
                end
            end
            ST_BUSY: begin
                // A start seen while busy is a protocol violation and is ignored.
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    rd_d    = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- scoreboard FSM: outputs ----------------
    always_comb begin
        busy    = (state_q == ST_BUSY);
        md_done = (state_q == ST_BUSY) && (cnt_q == 4'd1);
    end

    // ---------------- hazard detection ----------------
    always_comb begin
        lw_hz = (hz.i_is_load_e && d_reads(hz.i_rd_addr_e, hz.i_rs1_addr_d, hz.i_rs2_addr_d))
             || (LW_M_EN && hz.i_is_load_m
                 && d_reads(hz.i_rd_addr_m, hz.i_rs1_addr_d, hz.i_rs2_addr_d));
        // RAW/WAW only against a real destination; structural blocking also
        // covers ops writing x0. The done cycle is still covered because the
        // register file write happens on the edge that ends it.
        md_hz = busy && (hz.i_md_op_d
                         || d_reads(rd_q, hz.i_rs1_addr_d, hz.i_rs2_addr_d)
                         || ((rd_q != '0) && (hz.i_rd_addr_d == rd_q)));
        redirect = (hz.i_src_pc != 2'b00);
        // A redirect flushes the stalled instruction anyway, so it overrides.
        stall    = (lw_hz || md_hz) && !redirect;
    end

    // ---------------- performance counters ----------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.i_cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + CNT_BW'(1);
            if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_BW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ---------------- output mapping ----------------
    assign hz.o_forward_ae = fwd_sel(hz.i_rs1_addr_e, hz.i_rd_addr_m, hz.i_reg_wr_en_m,
                                     hz.i_rd_addr_w, hz.i_reg_wr_en_w);
    assign hz.o_forward_be = fwd_sel(hz.i_rs2_addr_e, hz.i_rd_addr_m, hz.i_reg_wr_en_m,
                                     hz.i_rd_addr_w, hz.i_reg_wr_en_w);
    assign hz.o_stall_f    = stall;
    assign hz.o_stall_d    = stall;
    assign hz.o_flush_d    = redirect;
    assign hz.o_flush_e    = redirect || stall;
    assign hz.o_md_busy    = busy;
    assign hz.o_md_rd      = rd_q;
    assign hz.o_md_done    = md_done;
    assign hz.o_stall_cnt  = stall_cnt_q;
    assign hz.o_flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_riscv_hazard_scoreboard
//   Two instances share one stimulus stream:
//     a : MD_LAT=4, LOAD_LAT=1, CNT_BW=16
//     b : MD_LAT=2, LOAD_LAT=2, CNT_BW=4
//   Expected values come from a cycle-numbered reference model: the
//   multi-cycle op is busy for the MD_LAT cycles following its start edge.
// ---------------------------------------------------------------------------
module tb_riscv_hazard_scoreboard;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    riscv_hazard_scoreboard_if #(.REG_ADDR_BW(5), .CNT_BW(16)) if_a ();
    riscv_hazard_scoreboard_if #(.REG_ADDR_BW(5), .CNT_BW(4))  if_b ();

    riscv_hazard_scoreboard #(.REG_ADDR_BW(5), .MD_LAT(4), .LOAD_LAT(1), .CNT_BW(16))
        u_dut_a (.i_clk(clk), .i_rstn(rstn), .hz(if_a));
    riscv_hazard_scoreboard #(.REG_ADDR_BW(5), .MD_LAT(2), .LOAD_LAT(2), .CNT_BW(4))
        u_dut_b (.i_clk(clk), .i_rstn(rstn), .hz(if_b));

    typedef struct packed {
        logic [4:0] rs1_d, rs2_d, rd_d;
        logic       md_op_d;
        logic [4:0] rs1_e, rs2_e, rd_e;
        logic       is_load_e, md_start_e;
        logic [4:0] rd_m;
        logic       wr_m, is_load_m;
        logic [4:0] rd_w;
        logic       wr_w;
        logic [1:0] src_pc;
        logic       cnt_clr;
    } stim_t;

    stim_t s;

    // Reference model
    int         lat  [2] = '{4, 2};
    int         llat [2] = '{1, 2};
    int         cmax [2] = '{65535, 15};
    bit         m_act   [2];
    int         m_start [2];
    logic [4:0] m_rd    [2];
    int         m_stall [2];
    int         m_flush [2];
    int         cyc;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic apply();
        if_a.i_rs1_addr_d = s.rs1_d;  if_b.i_rs1_addr_d = s.rs1_d;
        if_a.i_rs2_addr_d = s.rs2_d;  if_b.i_rs2_addr_d = s.rs2_d;
        if_a.i_rd_addr_d  = s.rd_d;   if_b.i_rd_addr_d  = s.rd_d;
        if_a.i_md_op_d    = s.md_op_d; if_b.i_md_op_d   = s.md_op_d;
        if_a.i_rs1_addr_e = s.rs1_e;  if_b.i_rs1_addr_e = s.rs1_e;
        if_a.i_rs2_addr_e = s.rs2_e;  if_b.i_rs2_addr_e = s.rs2_e;
        if_a.i_rd_addr_e  = s.rd_e;   if_b.i_rd_addr_e  = s.rd_e;
        if_a.i_is_load_e  = s.is_load_e;  if_b.i_is_load_e  = s.is_load_e;
        if_a.i_md_start_e = s.md_start_e; if_b.i_md_start_e = s.md_start_e;
        if_a.i_rd_addr_m  = s.rd_m;   if_b.i_rd_addr_m  = s.rd_m;
        if_a.i_reg_wr_en_m = s.wr_m;  if_b.i_reg_wr_en_m = s.wr_m;
        if_a.i_is_load_m  = s.is_load_m; if_b.i_is_load_m = s.is_load_m;
        if_a.i_rd_addr_w  = s.rd_w;   if_b.i_rd_addr_w  = s.rd_w;
        if_a.i_reg_wr_en_w = s.wr_w;  if_b.i_reg_wr_en_w = s.wr_w;
        if_a.i_src_pc     = s.src_pc; if_b.i_src_pc     = s.src_pc;
        if_a.i_cnt_clr    = s.cnt_clr; if_b.i_cnt_clr   = s.cnt_clr;
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (s.wr_m && s.rd_m == src) return 2'b10;
        if (s.wr_w && s.rd_w == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_busy(input int k);
        return m_act[k] && (cyc >= m_start[k]) && (cyc - m_start[k] < lat[k]);
    endfunction

    function automatic bit exp_done(input int k);
        return exp_busy(k) && (cyc - m_start[k] == lat[k] - 1);
    endfunction

    function automatic bit d_uses(input logic [4:0] r);
        return (r != 5'd0) && (s.rs1_d == r || s.rs2_d == r);
    endfunction

    function automatic bit exp_stall(input int k);
        bit lw, md;
        lw = (s.is_load_e && d_uses(s.rd_e)) || (llat[k] == 2 && s.is_load_m && d_uses(s.rd_m));
        md = exp_busy(k) && (s.md_op_d || d_uses(m_rd[k]) || (m_rd[k] != 5'd0 && s.rd_d == m_rd[k]));
        return (lw || md) && (s.src_pc == 2'b00);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 1'b0; m_start[k] = 0; m_rd[k] = '0; m_stall[k] = 0; m_flush[k] = 0;
        end
    endtask

    task automatic model_update();
        if (!rstn) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit st, bz;
                st = exp_stall(k);
                bz = exp_busy(k);
                if (s.cnt_clr) begin
                    m_stall[k] = 0; m_flush[k] = 0;
                end else begin
                    if (st && m_stall[k] < cmax[k]) m_stall[k]++;
                    if (s.src_pc != 2'b00 && m_flush[k] < cmax[k]) m_flush[k]++;
                end
                if (s.md_start_e && !bz) begin
                    m_act[k] = 1'b1; m_start[k] = cyc + 1; m_rd[k] = s.rd_e;
                end
            end
        end
        cyc++;
    endtask

    task automatic check_inst(input int k, input string p,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic sf, input logic sd, input logic fd, input logic fe,
                              input logic bz, input logic dn, input logic [4:0] mrd,
                              input logic [31:0] sc, input logic [31:0] fc);
        bit st, rdr;
        st  = exp_stall(k);
        rdr = (s.src_pc != 2'b00);
        check({p, "_fwd_ae"},  32'(fa), 32'(exp_fwd(s.rs1_e)));
        check({p, "_fwd_be"},  32'(fb), 32'(exp_fwd(s.rs2_e)));
        check({p, "_stall_f"}, 32'(sf), 32'(st));
        check({p, "_stall_d"}, 32'(sd), 32'(st));
        check({p, "_flush_d"}, 32'(fd), 32'(rdr));
        check({p, "_flush_e"}, 32'(fe), 32'(rdr | st));
        check({p, "_md_busy"}, 32'(bz), 32'(exp_busy(k)));
        check({p, "_md_done"}, 32'(dn), 32'(exp_done(k)));
        if (exp_busy(k)) check({p, "_md_rd"}, 32'(mrd), 32'(m_rd[k]));
        check({p, "_stall_cnt"}, sc, 32'(m_stall[k]));
        check({p, "_flush_cnt"}, fc, 32'(m_flush[k]));
    endtask

    task automatic check_all();
        check_inst(0, "a", if_a.o_forward_ae, if_a.o_forward_be, if_a.o_stall_f, if_a.o_stall_d,
                   if_a.o_flush_d, if_a.o_flush_e, if_a.o_md_busy, if_a.o_md_done, if_a.o_md_rd,
                   32'(if_a.o_stall_cnt), 32'(if_a.o_flush_cnt));
        check_inst(1, "b", if_b.o_forward_ae, if_b.o_forward_be, if_b.o_stall_f, if_b.o_stall_d,
                   if_b.o_flush_d, if_b.o_flush_e, if_b.o_md_busy, if_b.o_md_done, if_b.o_md_rd,
                   32'(if_b.o_stall_cnt), 32'(if_b.o_flush_cnt));
    endtask

    // Drive at the falling edge, compare 1 time unit later.
    task automatic step();
        apply();
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic async_reset();
        s = '0;
        apply();
        rstn = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst_busy_a", 32'(if_a.o_md_busy), 32'd0);
        check("rst_done_a", 32'(if_a.o_md_done), 32'd0);
        tick();
        rstn = 1'b1;
    endtask

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    initial begin
        cyc = 0;
        model_reset();
        s = '0;
        apply();
        rstn = 1'b0;
        #1;
        check_all();
        check("reset_stall_cnt_a", 32'(if_a.o_stall_cnt), 32'd0);
        @(negedge clk);
        tick();
        rstn = 1'b1;

        // Forwarding priority and x0 handling
        s = '0; s.rs1_e = 5'd5; s.rd_m = 5'd5; s.wr_m = 1'b1; s.rd_w = 5'd5; s.wr_w = 1'b1;
        step();
        check("fwd_m_over_w", 32'(if_a.o_forward_ae), 32'd2);
        s.rs1_e = 5'd0;
        step();
        check("fwd_x0", 32'(if_a.o_forward_ae), 32'd0);
        s.rs2_e = 5'd5; s.wr_m = 1'b0;
        step();
        check("fwd_w", 32'(if_a.o_forward_be), 32'd1);
        tick();

        // Load-use against x0, then a real dependency
        s = '0; s.is_load_e = 1'b1; s.rd_e = 5'd0; s.rs1_d = 5'd0;
        step();
        check("lu_x0_stall", 32'(if_a.o_stall_f), 32'd0);
        s.rd_e = 5'd7; s.rs2_d = 5'd7;
        step();
        check("lu_stall_f", 32'(if_a.o_stall_f), 32'd1);
        check("lu_stall_d", 32'(if_a.o_stall_d), 32'd1);
        check("lu_flush_e", 32'(if_a.o_flush_e), 32'd1);
        tick();

        // LOAD_LAT=2 load to x9: two bubbles on b, one on a
        s = '0; s.cnt_clr = 1'b1;
        step(); tick();
        s = '0; s.is_load_e = 1'b1; s.rd_e = 5'd9; s.rs1_d = 5'd9;
        step(); tick();
        s = '0; s.rs1_d = 5'd9; s.rd_m = 5'd9; s.wr_m = 1'b1; s.is_load_m = 1'b1;
        step();
        check("ll2_a_no_stall", 32'(if_a.o_stall_d), 32'd0);
        check("ll2_b_stall",    32'(if_b.o_stall_d), 32'd1);
        tick();
        s = '0; s.rs1_d = 5'd9; s.rd_w = 5'd9; s.wr_w = 1'b1;
        step();
        check("ll2_b_release", 32'(if_b.o_stall_d), 32'd0);
        check("ll2_b_cnt", 32'(if_b.o_stall_cnt), 32'd2);
        check("ll2_a_cnt", 32'(if_a.o_stall_cnt), 32'd1);
        tick();

        // Multi-cycle RAW: start rd=3, dependent held in D
        s = '0; s.md_start_e = 1'b1; s.rd_e = 5'd3;
        step(); tick();
        s = '0; s.rs1_d = 5'd3;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("md_raw_stall", 32'(if_a.o_stall_d), 32'(i <= 4));
            check("md_raw_done",  32'(if_a.o_md_done), 32'(i == 4));
            tick();
        end

        // Independent instruction never stalls; a second md op stalls until release
        s = '0; s.md_start_e = 1'b1; s.rd_e = 5'd3;
        step(); tick();
        for (int i = 1; i <= 5; i++) begin
            s = '0; s.rs1_d = 5'd8; s.rd_d = 5'd10; s.md_op_d = (i >= 3);
            step();
            check("md_struct_stall", 32'(if_a.o_stall_d), 32'(i == 3 || i == 4));
            tick();
        end

        // Redirect overrides a load-use stall
        s = '0; s.cnt_clr = 1'b1;
        step(); tick();
        s = '0; s.is_load_e = 1'b1; s.rd_e = 5'd7; s.rs2_d = 5'd7; s.src_pc = 2'b01;
        step();
        check("redir_stall",   32'(if_a.o_stall_f), 32'd0);
        check("redir_flush_d", 32'(if_a.o_flush_d), 32'd1);
        check("redir_flush_e", 32'(if_a.o_flush_e), 32'd1);
        tick();
        s = '0;
        step();
        check("redir_cnt", 32'(if_a.o_flush_cnt), 32'd1);
        tick();

        // Reset in the middle of an md op drops it
        s = '0; s.md_start_e = 1'b1; s.rd_e = 5'd3;
        step(); tick();
        s = '0;
        step(); tick();
        async_reset();
        for (int i = 0; i < 5; i++) begin
            s = '0;
            step();
            check("post_rst_no_done", 32'(if_a.o_md_done), 32'd0);
            tick();
        end

        // Counter saturation on b (4 bits) and clear priority
        for (int i = 0; i < 20; i++) begin
            s = '0; s.is_load_e = 1'b1; s.rd_e = 5'd4; s.rs1_d = 5'd4;
            step(); tick();
        end
        s = '0; s.is_load_e = 1'b1; s.rd_e = 5'd4; s.rs1_d = 5'd4; s.cnt_clr = 1'b1;
        step();
        check("sat_b", 32'(if_b.o_stall_cnt), 32'd15);
        check("nosat_a", 32'(if_a.o_stall_cnt), 32'd20);
        tick();
        s = '0;
        step();
        check("clr_prio_b", 32'(if_b.o_stall_cnt), 32'd0);
        check("clr_prio_a", 32'(if_a.o_stall_cnt), 32'd0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                async_reset();
            end else begin
                s.rs1_d      = rreg(); s.rs2_d = rreg(); s.rd_d = rreg();
                s.md_op_d    = ($urandom_range(0, 5) == 0);
                s.rs1_e      = rreg(); s.rs2_e = rreg(); s.rd_e = rreg();
                s.is_load_e  = ($urandom_range(0, 2) == 0);
                s.md_start_e = ($urandom_range(0, 4) == 0);
                s.rd_m       = rreg(); s.wr_m = 1'($urandom_range(0, 1));
                s.is_load_m  = ($urandom_range(0, 2) == 0);
                s.rd_w       = rreg(); s.wr_w = 1'($urandom_range(0, 1));
                s.src_pc     = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                s.cnt_clr    = ($urandom_range(0, 39) == 0);
                step();
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
